// File: rtl/alu_seq_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU sequencing arbiter.
package alu_seq_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP0,
    S_OP1,
    S_WAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/alu_seq_arbiter_if.sv
// Request, response and ALU-side signal bundle for alu_seq_arbiter.
interface alu_seq_arbiter_if
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [3:0]              req_op;
  logic [2*DATA_WIDTH-1:0] req_a;
  logic [2*DATA_WIDTH-1:0] req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_id;
  logic [DATA_WIDTH-1:0]   rsp_result;
  logic                    rsp_overflow;
  logic                    rsp_err;
  logic                    alu_opcode_valid;
  logic                    alu_opcode;
  logic [DATA_WIDTH-1:0]   alu_data;
  logic                    alu_done;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic                    alu_overflow;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
           alu_done, alu_result, alu_overflow,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_err,
           alu_opcode_valid, alu_opcode, alu_data
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
           alu_done, alu_result, alu_overflow,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_err,
           alu_opcode_valid, alu_opcode, alu_data
  );
endinterface

// File: rtl/alu_seq_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr;

  always_comb begin
    grant_id = req[1] & (~req[0] | ptr);
    grant    = '0;
    if (|req) grant = grant_id ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 ptr <= 1'b0;
    else if (grant_en && |req) ptr <= ~grant_id;
  end

endmodule

// File: rtl/alu_seq_arbiter.sv
// Shares one serial-opcode ALU between two requesters with round-robin arbitration.
// Define ALU_SEQ_TIMEOUT_EN to build the WAIT-state watchdog (TIMEOUT_CYCLES).
module alu_seq_arbiter
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_seq_arbiter_if.slave bus
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t                state, state_nx;
  logic                  accept;
  logic                  grant_id;
  logic [1:0]            grant;
  logic                  timeout_hit;
  logic [1:0]            sel_op;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic                  op_hi_q;
  logic [DATA_WIDTH-1:0] b_q;

  assign accept = (state == S_IDLE) && (|bus.req_valid) && !reset;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (bus.req_valid),
    .grant_en (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign bus.req_ready = accept ? grant : '0;
  assign sel_op = grant_id ? bus.req_op[3:2] : bus.req_op[1:0];
  assign sel_a  = grant_id ? bus.req_a[2*DATA_WIDTH-1 -: DATA_WIDTH] : bus.req_a[DATA_WIDTH-1:0];
  assign sel_b  = grant_id ? bus.req_b[2*DATA_WIDTH-1 -: DATA_WIDTH] : bus.req_b[DATA_WIDTH-1:0];
  assign bus.rsp_valid = (state == S_RESP);

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
  logic       err_q;

  // OP1 is the only way into WAIT, so clearing there clears on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 wait_cnt <= '0;
    else if (state == S_OP1)   wait_cnt <= '0;
    else if (state == S_WAIT)  wait_cnt <= wait_cnt + 8'd1;
  end

  assign timeout_hit = (state == S_WAIT) && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  err_q <= 1'b0;
    else if (state == S_WAIT && bus.alu_done)   err_q <= 1'b0;
    else if (timeout_hit)                       err_q <= 1'b1;
  end

  assign bus.rsp_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_OP0;
      S_OP0:   state_nx = S_OP1;
      S_OP1:   state_nx = S_WAIT;
      S_WAIT:  if (bus.alu_done || timeout_hit) state_nx = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // The first beat (op[0], a) loads straight into the ALU output registers at
  // accept, so only op[1] and b need holding for the second beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_hi_q              <= 1'b0;
      b_q                  <= '0;
      bus.rsp_id           <= 1'b0;
      bus.rsp_result       <= '0;
      bus.rsp_overflow     <= 1'b0;
      bus.alu_opcode_valid <= 1'b0;
      bus.alu_opcode       <= 1'b0;
      bus.alu_data         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_hi_q              <= sel_op[1];
            b_q                  <= sel_b;
            bus.rsp_id           <= grant_id;
            bus.alu_opcode_valid <= 1'b1;
            bus.alu_opcode       <= sel_op[0];
            bus.alu_data         <= sel_a;
          end
        end
        S_OP0: begin
          bus.alu_opcode <= op_hi_q;
          bus.alu_data   <= b_q;
        end
        S_OP1: begin
          bus.alu_opcode_valid <= 1'b0;
          bus.alu_opcode       <= 1'b0;
          bus.alu_data         <= '0;
        end
        S_WAIT: begin
          if (bus.alu_done) begin
            bus.rsp_result   <= bus.alu_result;
            bus.rsp_overflow <= bus.alu_overflow;
          end else if (timeout_hit) begin
            bus.rsp_result   <= '0;
            bus.rsp_overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_seq_arbiter.md
# alu_seq_arbiter

Controller that shares one `simple_alu` instance between two requesters. It accepts operation requests (2-bit opcode plus two operands) on a valid/ready handshake and arbitrates them round-robin. It serialises the granted request onto the ALU's `opcode_valid`/`opcode`/`data` protocol, waits for `done`, and returns `result`/`overflow` tagged with the requester id on a valid/ready response channel. It sits between the lab's stimulus agents and the ALU under test.

## Interface
Parameters:
- `DATA_WIDTH`, 8, operand/result width; must match the ALU.
- `TIMEOUT_CYCLES`, 16, WAIT-state watchdog limit; used only with the macro; range 1..255.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  bit i = requester i has a request.
- `req_ready`  out  2  bit i = request i accepted this cycle.
- `req_op`  in  4  {op1, op0}, 2 bits per requester.
- `req_a`  in  2*DATA_WIDTH  {a1, a0}, first operand.
- `req_b`  in  2*DATA_WIDTH  {b1, b0}, second operand.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_id`  out  1  requester that issued the response.
- `rsp_result`  out  DATA_WIDTH  ALU result.
- `rsp_overflow`  out  1  ALU overflow.
- `rsp_err`  out  1  timeout error flag.
- `alu_opcode_valid`  out  1  to ALU `opcode_valid`.
- `alu_opcode`  out  1  to ALU `opcode` (serial opcode bit).
- `alu_data`  out  DATA_WIDTH  to ALU `data`.
- `alu_done`  in  1  from ALU `done`.
- `alu_result`  in  DATA_WIDTH  from ALU `result`.
- `alu_overflow`  in  1  from ALU `overflow`.

## Operation
- FSM states: IDLE, OP0, OP1, WAIT, RESP.
- **IDLE**
  - If any `req_valid` bit is set, the arbiter grants g, and `req_ready[g]`=1 combinationally in that cycle.
  - Latch op/a/b/id of requester g, then go to OP0.
  - `req_ready` is 0 in every other state.
- **Arbitration**
  - One valid requester: it wins.
  - Both valid: the priority pointer picks the winner.
  - After a grant to i, the pointer becomes ~i.
  - The pointer resets to 0 and changes only on a grant.
- **OP0:** `alu_opcode_valid`=1, `alu_opcode`=op[0], `alu_data`=a. Go to OP1.
- **OP1:** `alu_opcode_valid`=1, `alu_opcode`=op[1], `alu_data`=b. Go to WAIT.
- **WAIT**
  - ALU outputs are 0.
  - When `alu_done`=1, capture `alu_result`/`alu_overflow` and go to RESP.
  - `alu_done` is ignored in all other states.
- **RESP**
  - `rsp_valid`=1, with `rsp_id`/`rsp_result`/`rsp_overflow`/`rsp_err` held stable.
  - When `rsp_ready`=1, go to IDLE.
- Opcode encoding: 00 ADD, 01 SUB, 10 AND, 11 OR. The block passes the opcode through without interpreting it.

## Timing
- Reset values:
  - State IDLE, pointer 0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_overflow`=0, `rsp_err`=0.
  - `alu_opcode_valid`=0, `alu_opcode`=0, `alu_data`=0.
- ALU-side outputs are registered, so they are a function of the current state and latched request only.
- Accept at cycle T: OP0 at T+1, OP1 at T+2, WAIT from T+3. The earliest `rsp_valid` is T+4 (done at T+3).
- The earliest next accept is the cycle after the `rsp_valid`&`rsp_ready` handshake.
- Reset mid-operation returns immediately to IDLE. Any in-flight request is dropped with no response.
- `req_*` data is sampled only in the accept cycle. Later changes have no effect.

## Configuration
- `ALU_SEQ_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to WAIT and increments every WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `alu_done`: go to RESP with `rsp_err`=1, `rsp_result`=0, `rsp_overflow`=0.
  - If `alu_done` arrives in the same cycle as expiry, done wins and `rsp_err`=0.
- Macro undefined:
  - No counter is built and `rsp_err` is tied 0.
  - WAIT lasts until `alu_done`, however long that takes.

## Structure
- Package `alu_seq_pkg` holds:
  - FSM state enum.
  - Opcode localparams `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`.
  - Default `DATA_WIDTH`.
- Sub-module `rr_arbiter2` holds:
  - Inputs: request vector and a grant-enable strobe.
  - Outputs: one-hot grant and the winning id.
  - Its own pointer register.

## Test plan
- **Single ADD:** reset; req0 op=00 a=8'h05 b=8'h03; ALU done after 1 WAIT cycle with 8'h08. Expect:
  - `req_ready`=2'b01 for one cycle.
  - `alu_opcode` 0 then 0; `alu_data` 05 then 03.
  - `rsp_valid` at T+4 with id=0, result=08.
- **Contention:** both requesters valid continuously. Grants go req0, req1, req0, req1, and the `rsp_id` sequence is 0,1,0,1.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles. `rsp_valid` stays 1 with stable data, and `req_ready` stays 0 throughout.
- **Overflow passthrough:** req1 op=00 a=8'hFF b=8'h01; ALU returns 8'h00 with overflow=1. Expect `rsp_overflow`=1, `rsp_id`=1.
- **Mid-op reset:** assert `reset` during WAIT. All outputs are 0 next cycle; after release, the first grant goes to req0 and the ALU ports stay idle until a new accept.
- **Timeout (macro on, `TIMEOUT_CYCLES`=4):** `alu_done` is never asserted. `rsp_err`=1 and `rsp_result`=0, with `rsp_valid` 4 cycles after WAIT entry. Separately, done at the expiry cycle gives `rsp_err`=0.
